dmem_hs: RTL and testbench

DMEM_HS -- requirements
Module: dmem_hs

---
 rtl/dmem_hs_pkg.sv | 9 +
 rtl/dmem_hs_align.sv | 28 ++
 rtl/dmem_hs.sv | 124 ++++++++++++
 tb/tb_dmem_hs.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_hs_pkg.sv
// dmem_hs_pkg: shared types and helpers for the handshaked data memory
// Holds the access-size and FSM state enums plus the alignment-fault check.
package dmem_hs_pkg;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_BAD = 2'b11} size_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_WAIT = 2'b01, S_RESP = 2'b10} state_e;
  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    return (sz == SZ_BAD) || (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_hs_align.sv
// dmem_hs_align: combinational byte-lane merge for stores and extraction/extension for loads
// Ports: size_i access size, off_i byte offset in word, unsigned_i zero-extend loads,
//        wdata_i LSB-aligned store data, word_i current memory word,
//        merged_o word after store, load_o extended load result.
module dmem_hs_align
  import dmem_hs_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);
  logic [4:0]  sh;
  logic [31:0] mask;
  logic [15:0] lo;
  always_comb begin
    sh = {off_i, 3'b000};
    mask = size_i == SZ_B ? 32'h0000_00ff << sh :
           size_i == SZ_H ? 32'h0000_ffff << sh : 32'hffff_ffff;
    merged_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
    lo = 16'(word_i >> sh);
    load_o = size_i == SZ_B ? {{24{~unsigned_i & lo[7]}}, lo[7:0]} :
             size_i == SZ_H ? {{16{~unsigned_i & lo[15]}}, lo} : word_i;
  end
endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: word-organised data memory with req/ready handshake and fixed wait states
// Ports: clk, rst (async, active-high); req/we/size/unsigned_ld/addr/wdata request side;
//        busy (not idle), ready (1-cycle completion), rdata/err (valid while ready).
// Build option: define DMEM_HS_ZERO_INIT_EN to clear all memory words on reset.
module dmem_hs
  import dmem_hs_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        we_q, uns_q;
  size_e       size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic        accept, fire, idle;
  logic        a_we, a_uns, a_err;
  size_e       a_size;
  logic [31:0] a_addr, a_wdata, a_off, word, merged, loaded;
  logic [AW-1:0] a_idx;
  // With zero wait states the access happens on the accept edge itself,
  // so the operands must come straight from the inputs rather than the latches.
  always_comb begin
    idle    = state_q == S_IDLE;
    accept  = idle && req;
    fire    = (accept && WAIT_CYCLES == 0) || (state_q == S_WAIT && cnt_q == 4'd0);
    a_we    = idle ? we : we_q;
    a_uns   = idle ? unsigned_ld : uns_q;
    a_size  = idle ? size_e'(size) : size_q;
    a_addr  = idle ? addr : addr_q;
    a_wdata = idle ? wdata : wdata_q;
    a_off   = a_addr - BASE_ADDR;
    a_idx   = AW'(a_off >> 2);
    a_err   = misaligned(a_size, a_addr[1:0]) || a_addr < BASE_ADDR || {1'b0, a_addr} >= END_ADDR;
    word    = mem_q[a_idx];
  end
  dmem_hs_align u_align (
    .size_i    (a_size),
    .off_i     (a_addr[1:0]),
    .unsigned_i(a_uns),
    .wdata_i   (a_wdata),
    .word_i    (word),
    .merged_o  (merged),
    .load_o    (loaded)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      state_d = WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
      cnt_d   = CNT_INIT;
    end else if (state_q == S_WAIT) begin
      state_d = cnt_q == 4'd0 ? S_RESP : S_WAIT;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == S_RESP) begin
      state_d = S_IDLE;
    end
    if (fire) begin
      err_d   = a_err;
      rdata_d = (a_err || a_we) ? 32'd0 : loaded;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      uns_q   <= unsigned_ld;
      size_q  <= size_e'(size);
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end
`ifdef DMEM_HS_ZERO_INIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
    end else if (fire && a_we && !a_err) begin
      mem_q[a_idx] <= merged;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (fire && a_we && !a_err) mem_q[a_idx] <= merged;
  end
`endif
  assign busy  = state_q != S_IDLE;
  assign ready = state_q == S_RESP;
  assign rdata = rdata_q;
  assign err   = err_q;
endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs: randomized and directed self-checking bench for dmem_hs against a behavioural model
module tb_dmem_hs;
  localparam int          DEPTH = 64;
  localparam int          W     = 2;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, unsigned_ld = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = BASE, wdata = 32'd0;
  logic        busy, ready, err;
  logic [31:0] rdata;
  int checks = 0, errors = 0;
  dmem_hs #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .busy(busy), .ready(ready), .rdata(rdata), .err(err)
  );
  always #5 clk = ~clk;
  logic [31:0] mmem [DEPTH];
  int          edge_n = 0;
  int          acc = -1000;
  logic        l_we, l_uns;
  logic [1:0]  l_size;
  logic [31:0] l_addr, l_wdata;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endtask
  task automatic model_access();
    longint a;
    int idx, sh;
    logic [31:0] w, v;
    logic bad;
    a = longint'(l_addr);
    bad = l_size == 2'd3 || (l_size == 2'd1 && l_addr[0]) || (l_size == 2'd2 && l_addr[1:0] != 2'd0) ||
          a < longint'(BASE) || a >= longint'(BASE) + 4 * DEPTH;
    m_err = bad;
    m_rdata = 32'd0;
    if (!bad) begin
      idx = int'((a - longint'(BASE)) / 4);
      sh = 8 * int'(a % 4);
      w = mmem[idx];
      if (l_we) begin
        if (l_size == 2'd0) w[sh+:8] = l_wdata[7:0];
        else if (l_size == 2'd1) w[sh+:16] = l_wdata[15:0];
        else w = l_wdata;
        mmem[idx] = w;
      end else begin
        v = w >> sh;
        if (l_size == 2'd0) begin
          v = v & 32'hFF;
          if (!l_uns && v >= 128) v = v - 256;
        end else if (l_size == 2'd1) begin
          v = v & 32'hFFFF;
          if (!l_uns && v >= 32768) v = v - 65536;
        end
        m_rdata = v;
      end
    end
  endtask
  // Model: a request accepted at edge n completes (access + ready) at edge n+W,
  // and the next request can only be taken from edge n+W+2 on.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      acc = -1000;
      m_rdata = 32'd0;
      m_err = 1'b0;
`ifdef DMEM_HS_ZERO_INIT_EN
      for (int i = 0; i < DEPTH; i++) mmem[i] = 32'd0;
`endif
    end else begin
      edge_n++;
      if (edge_n == acc + W) model_access();
      if (req && edge_n >= acc + W + 2) begin
        acc = edge_n;
        l_we = we; l_uns = unsigned_ld; l_size = size; l_addr = addr; l_wdata = wdata;
        if (W == 0) model_access();
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'(edge_n >= acc && edge_n <= acc + W));
      chk("ready", 32'(ready), 32'(edge_n == acc + W));
      chk("rdata", rdata, m_rdata);
      chk("err", 32'(err), 32'(m_err));
    end
  end
  task automatic access(input logic w_, input logic [1:0] s, input logic u, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic e, output int lat);
    req = 1'b1; we = w_; size = s; unsigned_ld = u; addr = a; wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      lat++;
    end while (!ready && lat < 20);
    if (!ready) chk("ready_timeout", 32'(lat), 32'(W + 1));
    rd = rdata;
    e = err;
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, nready, nrise;
    logic        pb;
    #22 rst = 1'b0;
    chk("rst_busy", 32'(busy), 0); chk("rst_ready", 32'(ready), 0);
    chk("rst_rdata", rdata, 0); chk("rst_err", 32'(err), 0);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) access(1'b1, 2'd2, 1'b0, BASE + 32'(4 * i), {16'hC0DE, 16'(i)}, rd, e, lat);
    access(1'b1, 2'd2, 1'b0, BASE + 32'h8, 32'hDEADBEEF, rd, e, lat);
    chk("st_w_err", 32'(e), 0); chk("st_w_rdata", rd, 0);
    access(1'b0, 2'd2, 1'b0, BASE + 32'h8, 32'd0, rd, e, lat);
    chk("ld_w_lat", 32'(lat), 3); chk("ld_w", rd, 32'hDEADBEEF); chk("ld_w_err", 32'(e), 0);
    access(1'b0, 2'd0, 1'b0, BASE + 32'h9, 32'd0, rd, e, lat);
    chk("ld_b_s", rd, 32'hFFFFFFBE);
    access(1'b0, 2'd0, 1'b1, BASE + 32'h9, 32'd0, rd, e, lat);
    chk("ld_b_u", rd, 32'h000000BE);
    access(1'b0, 2'd1, 1'b0, BASE + 32'hA, 32'd0, rd, e, lat);
    chk("ld_h_s", rd, 32'hFFFFDEAD);
    access(1'b1, 2'd0, 1'b0, BASE + 32'hB, 32'h55, rd, e, lat);
    access(1'b0, 2'd2, 1'b0, BASE + 32'h8, 32'd0, rd, e, lat);
    chk("ld_after_sb", rd, 32'h55ADBEEF);
    access(1'b1, 2'd2, 1'b0, BASE + 32'h6, 32'h11111111, rd, e, lat);
    chk("mis_err", 32'(e), 1); chk("mis_rdata", rd, 0);
    access(1'b0, 2'd2, 1'b0, BASE + 32'(4 * DEPTH), 32'd0, rd, e, lat);
    chk("oob_ld_err", 32'(e), 1); chk("oob_ld_rdata", rd, 0);
    access(1'b1, 2'd0, 1'b0, BASE + 32'(4 * DEPTH), 32'hAA, rd, e, lat);
    chk("oob_st_err", 32'(e), 1);
    access(1'b0, 2'd2, 1'b0, BASE + 32'h4, 32'd0, rd, e, lat);
    chk("ld_unchanged", rd, 32'hC0DE0001); chk("ld_unchanged_err", 32'(e), 0);
    req = 1'b1; we = 1'b0; size = 2'd2; addr = BASE + 32'h4;
    nready = 0; nrise = 0; pb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 11) req = 1'b0;
      if (ready) nready++;
      if (busy && !pb) nrise++;
      pb = busy;
    end
    chk("held_ready_pulses", 32'(nready), 3); chk("held_busy_rises", 32'(nrise), 3);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = BASE + 32'h10; wdata = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    #1 rst = 1'b1;
    #1 chk("arst_busy", 32'(busy), 0); chk("arst_ready", 32'(ready), 0);
    chk("arst_rdata", rdata, 0); chk("arst_err", 32'(err), 0);
    #1 rst = 1'b0;
    nready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    chk("arst_no_ready", 32'(nready), 0);
    access(1'b0, 2'd2, 1'b0, BASE + 32'h10, 32'd0, rd, e, lat);
`ifdef DMEM_HS_ZERO_INIT_EN
    chk("arst_old_value", rd, 32'h0);
`else
    chk("arst_old_value", rd, 32'hC0DE0004);
`endif
    for (int c = 0; c < 2000; c++) begin
      logic [1:0]  s;
      logic [31:0] a;
      s = ($urandom % 10 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom % 8)
        0: a = BASE - 32'($urandom_range(1, 8));
        1: a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 8)) - 32'd4;
        default: begin
          a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
          if ($urandom % 4 != 0) a = s == 2'd1 ? a & ~32'd1 : s == 2'd2 ? a & ~32'd3 : a;
        end
      endcase
      req = ($urandom % 10) < 7; we = 1'($urandom); unsigned_ld = 1'($urandom);
      size = s; addr = a; wdata = $urandom;
      if (c == 1000) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      @(negedge clk);
    end
    req = 1'b0;
    repeat (6) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
